// File: rtl/rib_dma.sv
// rib_dma: RIB word-copy DMA engine with a register-mapped config slave and a master port
module rib_dma #(
    parameter int LEN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_addr_i,
    input  logic [31:0] s_data_i,
    output logic [31:0] s_data_o,
    input  logic        s_we_i,
    input  logic [3:0]  s_sel_i,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    input  logic [31:0] m_data_i,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    input  logic        m_gnt_i,
    output logic        irq_o
);
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3;
    logic [1:0] state;
    logic [31:0] src, dst, wsrc, wdst, data_buf, src_new, dst_new;
    logic [LEN_W-1:0] len, remain, len_new;
    logic done, busy, ctrl_wr, start, abort, last_beat, unused_addr;
    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wdat, input logic [3:0] sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
    assign unused_addr = ^{s_addr_i[31:5], s_addr_i[1:0]};
    assign busy = state != IDLE;
    assign ctrl_wr = s_we_i && s_addr_i[4:2] == 3'd0 && s_sel_i[0];
    assign start = ctrl_wr && s_data_i[0];
    assign abort = ctrl_wr && s_data_i[3];
    assign src_new = lanes(src, s_data_i, s_sel_i) & ~32'h3;
    assign dst_new = lanes(dst, s_data_i, s_sel_i) & ~32'h3;
    assign len_new = LEN_W'(lanes(32'(len), s_data_i, s_sel_i));
    assign last_beat = m_gnt_i && remain == LEN_W'(1);
    assign m_req_o = state == RD || state == WR;
    assign m_we_o = state == WR;
    assign m_addr_o = state == RD ? wsrc : state == WR ? wdst : 32'h0;
    assign m_data_o = state == WR ? data_buf : 32'h0;
    assign m_sel_o = m_req_o ? 4'hF : 4'h0;
    assign irq_o = state == FIN;
    assign s_data_o = s_addr_i[4:2] == 3'd0 ? {28'h0, 1'b0, done, busy, 1'b0} :
                      s_addr_i[4:2] == 3'd1 ? src :
                      s_addr_i[4:2] == 3'd2 ? dst :
                      s_addr_i[4:2] == 3'd3 ? 32'(len) :
                      s_addr_i[4:2] == 3'd4 ? 32'(remain) : 32'h0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            src <= '0;
            dst <= '0;
            len <= '0;
            wsrc <= '0;
            wdst <= '0;
            remain <= '0;
            data_buf <= '0;
            done <= 1'b0;
        end else begin
            if (s_we_i && !busy) begin
                if (s_addr_i[4:2] == 3'd1) src <= src_new;
                if (s_addr_i[4:2] == 3'd2) dst <= dst_new;
                if (s_addr_i[4:2] == 3'd3) len <= len_new;
            end
            if (ctrl_wr && s_data_i[2]) done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= len == '0 ? FIN : RD;
                    wsrc <= src;
                    wdst <= dst;
                    remain <= len;
                end
                RD: if (abort) state <= FIN;
                    else if (m_gnt_i) begin
                        data_buf <= m_data_i;
                        state <= WR;
                    end
                WR: begin
                    // a write granted on the abort edge still counts as copied
                    if (m_gnt_i) begin
                        wsrc <= wsrc + 32'd4;
                        wdst <= wdst + 32'd4;
                        remain <= remain - LEN_W'(1);
                    end
                    state <= (abort || last_beat) ? FIN : m_gnt_i ? RD : WR;
                end
                default: begin
                    done <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
